// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector: pattern, length, overlap mode and match
// limit are set through a config handshake, then matches are counted in RUN.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_limit,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state_r, state_s;
  logic [MAX_LEN-1:0] pattern_r, pattern_s;
  logic [LEN_W-1:0]   len_r, len_s;
  logic               overlap_r, overlap_s;
  logic [CNT_W-1:0]   limit_r, limit_s;
  logic [MAX_LEN-1:0] history_r, history_s;
  logic [LEN_W-1:0]   fill_r, fill_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic               match_r, match_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               cfg_err_r, cfg_err_s;
  logic               cfg_ready_r, cfg_ready_s;

  logic               cfg_fire_s;
  logic               hit_s;
  logic [MAX_LEN-1:0] hist_shift_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic [CNT_W-1:0]   count_inc_s;

  // Compare only the low len bits of the shifted history against the pattern.
  function automatic logic pattern_hit(input logic [MAX_LEN-1:0] hist,
                                       input logic [MAX_LEN-1:0] pat,
                                       input logic [LEN_W-1:0]   len);
    logic [MAX_LEN-1:0] mask;
    mask = ~({MAX_LEN{1'b1}} << len);
    return ((hist ^ pat) & mask) == {MAX_LEN{1'b0}};
  endfunction

  assign cfg_ready   = cfg_ready_r;
  assign cfg_err     = cfg_err_r;
  assign match       = match_r;
  assign match_count = count_r;
  assign busy        = busy_r;
  assign done        = done_r;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_s      = state_r;
    pattern_s    = pattern_r;
    len_s        = len_r;
    overlap_s    = overlap_r;
    limit_s      = limit_r;
    history_s    = history_r;
    fill_s       = fill_r;
    count_s      = count_r;
    cfg_err_s    = cfg_err_r;
    hit_s        = 1'b0;
    cfg_fire_s   = cfg_valid & cfg_ready_r;
    hist_shift_s = {history_r[MAX_LEN-2:0], in_bit};
    fill_inc_s   = (fill_r < len_r) ? (fill_r + LEN_W'(1)) : len_r;
    count_inc_s  = count_r + CNT_W'(1);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (cfg_fire_s) begin
          pattern_s = cfg_pattern;
          len_s     = cfg_len;
          overlap_s = cfg_overlap;
          limit_s   = cfg_limit;
          cfg_err_s = (cfg_len == {LEN_W{1'b0}}) || (cfg_len > MAX_LEN_L);
        end else if (start && !cfg_err_r) begin
          state_s   = ST_RUN;
          history_s = {MAX_LEN{1'b0}};
          fill_s    = {LEN_W{1'b0}};
          count_s   = {CNT_W{1'b0}};
        end else if (stop && (state_r == ST_DONE)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          history_s = hist_shift_s;
          hit_s     = (fill_inc_s == len_r) && pattern_hit(hist_shift_s, pattern_r, len_r);
          if (hit_s) begin
            count_s = count_inc_s;
            // Non-overlapping mode restarts the fill so no bit is reused.
            fill_s  = overlap_r ? fill_inc_s : {LEN_W{1'b0}};
          end else begin
            fill_s = fill_inc_s;
          end
        end else begin
          hit_s = 1'b0;
        end
        if (stop) begin
          state_s = ST_IDLE;
        end else if (hit_s && (limit_r != {CNT_W{1'b0}}) && (count_inc_s == limit_r)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    match_s     = hit_s;
    busy_s      = (state_s == ST_RUN);
    done_s      = (state_s == ST_DONE);
    cfg_ready_s = (state_s != ST_RUN);
  end

  // State, configuration, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      pattern_r   <= {MAX_LEN{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      overlap_r   <= 1'b0;
      limit_r     <= {CNT_W{1'b0}};
      history_r   <= {MAX_LEN{1'b0}};
      fill_r      <= {LEN_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      match_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
      cfg_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      pattern_r   <= pattern_s;
      len_r       <= len_s;
      overlap_r   <= overlap_s;
      limit_r     <= limit_s;
      history_r   <= history_s;
      fill_r      <= fill_s;
      count_r     <= count_s;
      match_r     <= match_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      cfg_err_r   <= cfg_err_s;
      cfg_ready_r <= cfg_ready_s;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl with hand-computed match
// positions and counts for each stimulus step.
module tb_seq_detect_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_limit;
  logic       cfg_err;
  logic       start;
  logic       stop;
  logic       in_valid;
  logic       in_bit;
  logic       match;
  logic [7:0] match_count;
  logic       busy;
  logic       done;

  int passed;
  int total;

  seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
    .cfg_err(cfg_err), .start(start), .stop(stop),
    .in_valid(in_valid), .in_bit(in_bit), .match(match),
    .match_count(match_count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                        input logic ov, input logic [7:0] lim);
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ov; cfg_limit = lim;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  // Bits go out MSB first; exp holds the expected match flag after each bit.
  task automatic send_seq(input string tag, input logic [15:0] bits,
                          input int n, input logic [15:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      in_valid = 1'b1; in_bit = bits[i];
      step();
      in_valid = 1'b0;
      chk($sformatf("%s_bit%0d", tag, n - i), {31'd0, match}, {31'd0, exp[i]});
    end
  endtask

  initial begin
    passed = 0; total = 0;
    rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = 8'd0; cfg_len = 4'd0;
    cfg_overlap = 1'b0; cfg_limit = 8'd0; start = 1'b0; stop = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0;
    step(); step();
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_count", {24'd0, match_count}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    rst = 1'b1;
    step();

    // 11011 non-overlapping over 1101111011
    do_cfg(8'b00011011, 4'd5, 1'b0, 8'd0);
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    send_seq("t1", 16'b1101111011, 10, 16'b0000100001);
    chk("t1_count", {24'd0, match_count}, 32'd2);
    in_bit = 1'b1; step();
    chk("t1_gap_count", {24'd0, match_count}, 32'd2);
    pulse_stop();
    chk("t1_stop_busy", {31'd0, busy}, 32'd0);
    chk("t1_stop_ready", {31'd0, cfg_ready}, 32'd1);

    // 11011 overlapping, then non-overlapping, over 11011011
    do_cfg(8'b00011011, 4'd5, 1'b1, 8'd0);
    pulse_start();
    send_seq("t2ov", 16'b11011011, 8, 16'b00001001);
    chk("t2ov_count", {24'd0, match_count}, 32'd2);
    pulse_stop();
    do_cfg(8'b00011011, 4'd5, 1'b0, 8'd0);
    pulse_start();
    chk("t2no_count_clr", {24'd0, match_count}, 32'd0);
    send_seq("t2no", 16'b11011011, 8, 16'b00001000);
    chk("t2no_count", {24'd0, match_count}, 32'd1);
    pulse_stop();

    // 101 overlapping with limit 2: DONE together with the second pulse
    do_cfg(8'b00000101, 4'd3, 1'b1, 8'd2);
    pulse_start();
    send_seq("t3", 16'b10101, 5, 16'b00101);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_count", {24'd0, match_count}, 32'd2);
    send_seq("t3_after", 16'b010, 3, 16'b000);
    chk("t3_count_held", {24'd0, match_count}, 32'd2);
    chk("t3_done_held", {31'd0, done}, 32'd1);
    chk("t3_ready", {31'd0, cfg_ready}, 32'd1);
    pulse_stop();
    chk("t3_stop_done", {31'd0, done}, 32'd0);

    // Illegal length blocks start; a legal re-config re-enables it
    do_cfg(8'b00001001, 4'd0, 1'b0, 8'd0);
    chk("t4_err_set", {31'd0, cfg_err}, 32'd1);
    pulse_start();
    chk("t4_start_ignored", {31'd0, busy}, 32'd0);
    do_cfg(8'b00001001, 4'd4, 1'b0, 8'd0);
    chk("t4_err_clr", {31'd0, cfg_err}, 32'd0);
    pulse_start();
    chk("t4_busy", {31'd0, busy}, 32'd1);
    send_seq("t4", 16'b1001, 4, 16'b0001);
    pulse_stop();

    // Stop together with a completing bit, then start with cfg in the same cycle
    do_cfg(8'b00000101, 4'd3, 1'b0, 8'd0);
    pulse_start();
    send_seq("t5", 16'b10, 2, 16'b00);
    in_valid = 1'b1; in_bit = 1'b1; stop = 1'b1;
    step();
    in_valid = 1'b0; stop = 1'b0;
    chk("t5_match", {31'd0, match}, 32'd1);
    chk("t5_count", {24'd0, match_count}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    start = 1'b1;
    do_cfg(8'b00000011, 4'd2, 1'b0, 8'd0);
    start = 1'b0;
    chk("t5_cfg_wins_busy", {31'd0, busy}, 32'd0);
    chk("t5_cfg_wins_ready", {31'd0, cfg_ready}, 32'd1);
    pulse_start();
    send_seq("t5_newcfg", 16'b011, 3, 16'b001);
    pulse_stop();

    // Asynchronous reset mid-RUN, then a fresh detection with no carry-over
    do_cfg(8'b00011011, 4'd5, 1'b0, 8'd0);
    pulse_start();
    send_seq("t6_pre", 16'b110, 3, 16'b000);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("t6_rst_count", {24'd0, match_count}, 32'd0);
    chk("t6_rst_match", {31'd0, match}, 32'd0);
    step();
    rst = 1'b1;
    pulse_start();
    chk("t6_cfg_lost", {31'd0, busy}, 32'd1);
    pulse_stop();
    do_cfg(8'b00011011, 4'd5, 1'b0, 8'd0);
    pulse_start();
    send_seq("t6", 16'b11011, 5, 16'b00001);
    chk("t6_count", {24'd0, match_count}, 32'd1);
    pulse_stop();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
